// File: rtl/edge_tap_delay.sv
// edge_tap_delay: single-bit edge detector plus a variable-tap shift-register delay line
// Ports: clk, rst_n (async active-low), ce (enable for both registers)
//        i -> pe/ne/ee (edges of i against its last enabled sample)
//        d -> q (d delayed a+1 enabled clocks, tap select a)
module edge_tap_delay #(
  parameter int WID = 1,
  parameter int DEP = 16,
  localparam int AW = $clog2(DEP)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           i,
  output logic           pe,
  output logic           ne,
  output logic           ee,
  input  logic [AW-1:0]  a,
  input  logic [WID-1:0] d,
  output logic [WID-1:0] q
);
  logic           ed_q, ed_d;
  logic [WID-1:0] s_q [DEP];
  logic [WID-1:0] s_d [DEP];
  always_comb begin
    ed_d = ce ? i : ed_q;
    s_d[0] = ce ? d : s_q[0];
    for (int k = 1; k < DEP; k++) s_d[k] = ce ? s_q[k-1] : s_q[k];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ed_q <= 1'b0;
      for (int k = 0; k < DEP; k++) s_q[k] <= '0;
    end else begin
      ed_q <= ed_d;
      s_q <= s_d;
    end
  end
  assign pe = i & ~ed_q;
  assign ne = ~i & ed_q;
  assign ee = i ^ ed_q;
  assign q  = s_q[a];
endmodule

// File: tb/tb_edge_tap_delay.sv
// tb_edge_tap_delay: randomized and directed checks of edge_tap_delay against a sample-history model
module tb_edge_tap_delay;
  localparam int WID = 8, DEP = 16, AW = 4;
  logic clk = 0, rst_n = 0, ce = 0, i = 0;
  logic [AW-1:0] a = '0;
  logic [WID-1:0] d = '0;
  logic pe, ne, ee;
  logic [WID-1:0] q;
  int total = 0, bad = 0;
  logic [WID-1:0] hist[$];
  logic ed_m;
  edge_tap_delay #(.WID(WID), .DEP(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .i(i), .pe(pe), .ne(ne), .ee(ee),
    .a(a), .d(d), .q(q)
  );
  always #5 clk = ~clk;
  task automatic model_rst;
    hist.delete();
    repeat (DEP) hist.push_back('0);
    ed_m = 1'b0;
  endtask
  task automatic tick;
    @(posedge clk);
    if (rst_n && ce) begin
      hist.push_front(d);
      void'(hist.pop_back());
      ed_m = i;
    end
    #1;
  endtask
  task automatic flush;
    ce = 1; d = '0; i = 0;
    repeat (DEP + 1) tick();
  endtask
  task automatic test_reset;
    logic [AW-1:0] taps [4] = '{4'd0, 4'd1, 4'd2, 4'd15};
    rst_n = 0; ce = 1; d = 8'h01; i = 1;
    model_rst();
    repeat (3) begin
      tick();
      foreach (taps[t]) begin
        a = taps[t];
        #1;
        total++;
        if (q !== 8'h00) begin bad++; $display("FAIL reset_q a=%0d got=%h exp=00", a, q); end
      end
      total++;
      if ({pe, ne, ee} !== 3'b101) begin bad++; $display("FAIL reset_edges got=%b exp=101", {pe, ne, ee}); end
    end
    i = 0; d = '0;
    tick();
    rst_n = 1;
  endtask
  task automatic test_rise_fall;
    ce = 1;
    for (int c = 0; c < 13; c++) begin
      i = (c >= 5 && c <= 8);
      a = AW'($urandom_range(0, DEP - 1));
      d = WID'($urandom);
      #2;
      total++;
      if ({pe, ne, ee} !== {c == 5, c == 9, c == 5 || c == 9}) begin
        bad++; $display("FAIL rise_fall c=%0d got=%b exp=%b", c, {pe, ne, ee}, {c == 5, c == 9, c == 5 || c == 9});
      end
      total++;
      if (q !== hist[a]) begin bad++; $display("FAIL rise_fall_q c=%0d got=%h exp=%h", c, q, hist[a]); end
      tick();
    end
  endtask
  task automatic test_taps(input int tap);
    flush();
    a = AW'(tap);
    for (int c = 0; c < 20; c++) begin
      d = WID'(c == 10);
      #2;
      total++;
      if (q !== WID'(c == 11 + tap)) begin bad++; $display("FAIL taps a=%0d c=%0d got=%h exp=%h", tap, c, q, WID'(c == 11 + tap)); end
      tick();
    end
  endtask
  task automatic test_full_depth;
    ce = 1; a = AW'(DEP - 1);
    for (int c = 0; c < DEP + 40; c++) begin
      d = WID'(c);
      #2;
      if (c >= DEP) begin
        total++;
        if (q !== WID'(c - DEP)) begin bad++; $display("FAIL full_depth c=%0d got=%h exp=%h", c, q, WID'(c - DEP)); end
      end
      tick();
    end
  endtask
  task automatic test_clock_enable;
    flush();
    a = 3;
    for (int c = 0; c < 15; c++) begin
      ce = !(c >= 3 && c <= 7);
      d = WID'(c == 0);
      i = (c >= 3);
      #2;
      total++;
      if (q !== WID'(c == 9)) begin bad++; $display("FAIL ce_q c=%0d got=%h exp=%h", c, q, WID'(c == 9)); end
      total++;
      if (pe !== (c >= 3 && c <= 8)) begin bad++; $display("FAIL ce_pe c=%0d got=%b exp=%b", c, pe, (c >= 3 && c <= 8)); end
      tick();
    end
  endtask
  task automatic test_async_reset;
    flush();
    a = 2;
    for (int c = 0; c < 3; c++) begin
      d = WID'(c == 0);
      tick();
    end
    d = '0;
    #1;
    total++;
    if (q !== 8'h01) begin bad++; $display("FAIL areset_pre got=%h exp=01", q); end
    #1;
    rst_n = 0;
    model_rst();
    #1;
    total++;
    if (q !== 8'h00) begin bad++; $display("FAIL areset_drop got=%h exp=00", q); end
    tick();
    rst_n = 1;
    for (int c = 0; c < 20; c++) begin
      #2;
      total++;
      if (q !== 8'h00) begin bad++; $display("FAIL areset_after c=%0d got=%h exp=00", c, q); end
      tick();
    end
  endtask
  task automatic test_random;
    for (int c = 0; c < 300; c++) begin
      ce = ($urandom_range(0, 3) != 0);
      i = $urandom_range(0, 1);
      d = WID'($urandom);
      a = AW'($urandom_range(0, DEP - 1));
      #2;
      total++;
      if (q !== hist[a]) begin bad++; $display("FAIL random_q c=%0d a=%0d got=%h exp=%h", c, a, q, hist[a]); end
      total++;
      if ({pe, ne, ee} !== {i & ~ed_m, ~i & ed_m, i ^ ed_m}) begin
        bad++; $display("FAIL random_edges c=%0d got=%b exp=%b", c, {pe, ne, ee}, {i & ~ed_m, ~i & ed_m, i ^ ed_m});
      end
      tick();
    end
  endtask
  initial begin
    model_rst();
    test_reset();
    test_rise_fall();
    test_taps(2);
    test_taps(1);
    test_full_depth();
    test_clock_enable();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
